// File: rtl/ld_exec_unit.sv
// Load execution unit: pops the load queue head, issues a word read to the
// data cache, formats the returned data and broadcasts it for one cycle.
module ld_exec_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        head_ready,
   input  logic [4:0]  head_id,
   input  logic [31:0] head_address,
   input  logic [2:0]  head_funct3,
   output logic        del_head,
   output logic        dmem_read,
   output logic [31:0] dmem_address,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic [4:0]  ld_reg_id,
   output logic [31:0] ld_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEM   = 2'd1,
      BCAST = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_id;
   logic [31:0] r_addr;
   logic [2:0]  r_f3;
   logic [31:0] r_rdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_fmt;

   // A new head may be taken while idle or while the previous result is on the bus.
   assign del_head = head_ready && (r_state == IDLE || r_state == BCAST) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_id    <= '0;
         r_addr  <= '0;
         r_f3    <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (del_head) begin
            r_id   <= head_id;
            r_addr <= head_address;
            r_f3   <= head_funct3;
         end
         if (r_state == MEM && dmem_resp) begin
            r_rdata <= dmem_rdata;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (del_head) w_next = MEM;
         MEM:     if (dmem_resp) w_next = BCAST;
         BCAST:   w_next = del_head ? MEM : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_byte = r_rdata[7:0];
      unique case (r_addr[1:0])
         2'd0: w_byte = r_rdata[7:0];
         2'd1: w_byte = r_rdata[15:8];
         2'd2: w_byte = r_rdata[23:16];
         2'd3: w_byte = r_rdata[31:24];
         default: w_byte = r_rdata[7:0];
      endcase
      w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
      // Unrecognised funct3 encodings fall through to a plain word load.
      unique case (r_f3)
         3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_fmt = {24'd0, w_byte};
         3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
         3'b101:  w_fmt = {16'd0, w_half};
         default: w_fmt = r_rdata;
      endcase
   end

   assign dmem_read    = (r_state == MEM);
   assign dmem_address = (r_state == MEM) ? {r_addr[31:2], 2'b00} : 32'd0;
   assign ld_reg_id    = (r_state == BCAST) ? r_id : 5'd0;
   assign ld_data      = (r_state == BCAST) ? w_fmt : 32'd0;

endmodule

// File: tb/tb_ld_exec_unit.sv
// Self-checking bench for ld_exec_unit: directed scenarios plus randomized
// loads compared against a transaction-level formatting model.
module tb_ld_exec_unit;

   logic        clk;
   logic        rst;
   logic        head_ready;
   logic [4:0]  head_id;
   logic [31:0] head_address;
   logic [2:0]  head_funct3;
   logic        del_head;
   logic        dmem_read;
   logic [31:0] dmem_address;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [4:0]  ld_reg_id;
   logic [31:0] ld_data;

   int totalChecks = 0;
   int badChecks   = 0;

   ld_exec_unit dut (
      .clk          (clk),
      .rst          (rst),
      .head_ready   (head_ready),
      .head_id      (head_id),
      .head_address (head_address),
      .head_funct3  (head_funct3),
      .del_head     (del_head),
      .dmem_read    (dmem_read),
      .dmem_address (dmem_address),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .ld_reg_id    (ld_reg_id),
      .ld_data      (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference: pick the addressed byte/half arithmetically and extend it.
   function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] f3);
      logic [31:0] off;
      logic [31:0] b;
      logic [31:0] h;
      off = addr % 4;
      b = (word >> (8 * off)) & 32'hFF;
      h = (word >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 32'd256 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   // Full load from idle: accept, waitCycles stalled MEM cycles, response, one broadcast.
   task automatic applyStimulus(input logic [4:0] id, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] word, input int waitCycles, input bit keepReady);
      logic [31:0] wordAddr;
      wordAddr = addr & 32'hFFFF_FFFC;
      head_ready = 1'b1; head_id = id; head_address = addr; head_funct3 = f3;
      #1;
      checkOutput("del_head_accept", {31'd0, del_head}, 32'd1);
      @(negedge clk);
      head_ready = keepReady;
      for (int i = 0; i <= waitCycles; i++) begin
         #1;
         checkOutput("dmem_read_mem", {31'd0, dmem_read}, 32'd1);
         checkOutput("dmem_addr_mem", dmem_address, wordAddr);
         checkOutput("del_head_mem", {31'd0, del_head}, 32'd0);
         checkOutput("no_bcast_mem", {27'd0, ld_reg_id}, 32'd0);
         if (i == waitCycles) begin
            dmem_resp = 1'b1;
            dmem_rdata = word;
         end else begin
            dmem_rdata = $urandom;
         end
         @(negedge clk);
      end
      dmem_resp = 1'b0;
      dmem_rdata = $urandom;
      head_ready = 1'b0;
      #1;
      checkOutput("bcast_id", {27'd0, ld_reg_id}, {27'd0, id});
      checkOutput("bcast_data", ld_data, refLoad(word, addr, f3));
      checkOutput("bcast_read_low", {31'd0, dmem_read}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("post_bcast_id", {27'd0, ld_reg_id}, 32'd0);
      checkOutput("post_bcast_data", ld_data, 32'd0);
      checkOutput("post_bcast_read", {31'd0, dmem_read}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; head_ready = 1'b1; head_id = 5'd9; head_address = 32'h44;
      head_funct3 = 3'b010; dmem_rdata = '0; dmem_resp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_del_head", {31'd0, del_head}, 32'd0);
      checkOutput("rst_dmem_read", {31'd0, dmem_read}, 32'd0);
      checkOutput("rst_dmem_addr", dmem_address, 32'd0);
      checkOutput("rst_reg_id", {27'd0, ld_reg_id}, 32'd0);
      checkOutput("rst_data", ld_data, 32'd0);
      head_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] LW with one-cycle cache");
      applyStimulus(5'd7, 32'h1000, 3'b010, 32'hDEADBEEF, 1, 1'b0);

      $display("[TB] byte and half extension");
      applyStimulus(5'd1, 32'h2003, 3'b000, 32'h80FF7F01, 0, 1'b0);
      checkOutput("ref_lb_2003", refLoad(32'h80FF7F01, 32'h2003, 3'b000), 32'hFFFFFF80);
      applyStimulus(5'd2, 32'h2003, 3'b100, 32'h80FF7F01, 0, 1'b0);
      applyStimulus(5'd3, 32'h2000, 3'b000, 32'h80FF7F01, 0, 1'b0);
      applyStimulus(5'd4, 32'h2002, 3'b001, 32'h80FF7F01, 0, 1'b0);
      applyStimulus(5'd5, 32'h2000, 3'b101, 32'h80FF7F01, 0, 1'b0);
      applyStimulus(5'd6, 32'h2001, 3'b010, 32'h80FF7F01, 0, 1'b0);

      $display("[TB] stalled cache");
      applyStimulus(5'd11, 32'h3006, 3'b001, 32'h1234_F678, 5, 1'b1);

      $display("[TB] back-to-back");
      head_ready = 1'b1; head_id = 5'd3; head_address = 32'h4001; head_funct3 = 3'b100;
      #1;
      checkOutput("b2b_pop1", {31'd0, del_head}, 32'd1);
      @(negedge clk);
      head_id = 5'd4; head_address = 32'h5006; head_funct3 = 3'b001;
      #1;
      checkOutput("b2b_mem1_del", {31'd0, del_head}, 32'd0);
      checkOutput("b2b_mem1_addr", dmem_address, 32'h4000);
      dmem_resp = 1'b1; dmem_rdata = 32'hA5A5_C3C3;
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      checkOutput("b2b_bcast1_id", {27'd0, ld_reg_id}, 32'd3);
      checkOutput("b2b_bcast1_data", ld_data, refLoad(32'hA5A5_C3C3, 32'h4001, 3'b100));
      checkOutput("b2b_pop2", {31'd0, del_head}, 32'd1);
      @(negedge clk);
      head_ready = 1'b0;
      #1;
      checkOutput("b2b_mem2_read", {31'd0, dmem_read}, 32'd1);
      checkOutput("b2b_mem2_addr", dmem_address, 32'h5004);
      checkOutput("b2b_mem2_nobcast", {27'd0, ld_reg_id}, 32'd0);
      dmem_resp = 1'b1; dmem_rdata = 32'h8001_7FFE;
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      checkOutput("b2b_bcast2_id", {27'd0, ld_reg_id}, 32'd4);
      checkOutput("b2b_bcast2_data", ld_data, refLoad(32'h8001_7FFE, 32'h5006, 3'b001));
      @(negedge clk);
      #1;
      checkOutput("b2b_idle_id", {27'd0, ld_reg_id}, 32'd0);

      $display("[TB] reset in MEM");
      head_ready = 1'b1; head_id = 5'd12; head_address = 32'h6000; head_funct3 = 3'b010;
      @(negedge clk);
      head_ready = 1'b0;
      #1;
      checkOutput("rstmem_read_before", {31'd0, dmem_read}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstmem_read", {31'd0, dmem_read}, 32'd0);
      checkOutput("rstmem_addr", dmem_address, 32'd0);
      checkOutput("rstmem_id", {27'd0, ld_reg_id}, 32'd0);
      checkOutput("rstmem_data", ld_data, 32'd0);
      checkOutput("rstmem_del", {31'd0, del_head}, 32'd0);
      dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_resp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checkOutput("rstmem_no_bcast", {27'd0, ld_reg_id}, 32'd0);
         checkOutput("rstmem_no_read", {31'd0, dmem_read}, 32'd0);
         @(negedge clk);
      end
      applyStimulus(5'd13, 32'h6002, 3'b101, 32'hCAFE_0001, 0, 1'b0);

      $display("[TB] spurious response in IDLE");
      dmem_resp = 1'b1; dmem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      dmem_resp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checkOutput("spur_no_bcast", {27'd0, ld_reg_id}, 32'd0);
         checkOutput("spur_no_read", {31'd0, dmem_read}, 32'd0);
         @(negedge clk);
      end

      $display("[TB] randomized loads");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(5'($urandom), $urandom, 3'($urandom), $urandom,
                       int'($urandom_range(0, 4)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
